// File: rtl/p_update_sequencer_pkg.sv
// Shared solver definitions: sequencer state encoding, the P word type and the
// address width used by the P, R and X memories.
package p_update_sequencer_pkg;

  localparam int unsigned SOLVER_ADDRESS_WIDTH = 20;
  localparam int unsigned P_EQUATIONS          = 9;
  localparam int unsigned P_ELEMENT_WIDTH      = 32;
  localparam int unsigned P_WORD_WIDTH         = P_EQUATIONS * P_ELEMENT_WIDTH;

  typedef logic [P_WORD_WIDTH-1:0] p_word_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

endpackage

// File: rtl/p_update_sequencer_credit_counter.sv
// Up/down count of operations issued but not yet returned, with full/empty flags.
module credit_counter #(
  parameter int unsigned max_count = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic inc,
  input  logic dec,
  output logic at_limit,
  output logic empty
);

  localparam int unsigned CW = $clog2(max_count + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (inc && !dec) begin
      count <= count + 1'b1;
    end else if (dec && !inc) begin
      count <= count - 1'b1;
    end
  end

  assign at_limit = (count == CW'(max_count));
  assign empty    = (count == '0);

endmodule

// File: rtl/p_update_sequencer.sv
// One update pass over P memory: read each word, hand it to the P-update
// datapath, and write the in-order results back to the same addresses.
module p_update_sequencer
  import p_update_sequencer_pkg::*;
#(
  parameter int unsigned number_of_clusters              = 1,
  parameter int unsigned number_of_equations_per_cluster = P_EQUATIONS,
  parameter int unsigned element_width                   = P_ELEMENT_WIDTH,
  parameter int unsigned address_width                   = SOLVER_ADDRESS_WIDTH,
  parameter int unsigned max_outstanding                 = 4
) (
  input  logic                                                     clk,
  input  logic                                                     rst,
  input  logic                                                     start,
  output logic                                                     busy,
  output logic                                                     done,
  output logic                                                     error,
  output logic [address_width-1:0]                                 mem_read_address,
  input  logic [number_of_equations_per_cluster*element_width-1:0] mem_read_data,
  output logic                                                     dp_op_valid,
  output logic [number_of_equations_per_cluster*element_width-1:0] dp_op_data,
  input  logic                                                     dp_op_ready,
  input  logic                                                     dp_res_valid,
  input  logic [number_of_equations_per_cluster*element_width-1:0] dp_res_data,
  output logic                                                     mem_write_enable,
  output logic [address_width-1:0]                                 mem_write_address,
  output logic [number_of_equations_per_cluster*element_width-1:0] mem_write_data
);

  localparam int unsigned CW = address_width + 1;
  localparam logic [CW-1:0] CLUSTERS = CW'(number_of_clusters);

  seq_state_t             state, state_next;
  logic [CW-1:0]          issue_cnt;
  logic [address_width-1:0] wb_cnt;
  logic                   start_accept, issue, res_accept;
  logic                   credit_full, credit_empty;

  assign start_accept     = (state == IDLE) && start;
  assign dp_op_valid      = (state == RUN) && (issue_cnt < CLUSTERS) && !credit_full;
  assign issue            = dp_op_valid && dp_op_ready;
  assign res_accept       = dp_res_valid && (state == RUN) && !credit_empty;
  assign mem_read_address = issue_cnt[address_width-1:0];
  assign dp_op_data       = mem_read_data;
  assign busy             = (state != IDLE);
  assign done             = (state == DONE);

  credit_counter #(
    .max_count(max_outstanding)
  ) u_credit (
    .clk     (clk),
    .rst     (rst),
    .clear   (start_accept),
    .inc     (issue),
    .dec     (res_accept),
    .at_limit(credit_full),
    .empty   (credit_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // An empty credit count means the last result was registered at the edge that
  // emptied it; that write commits on the same edge that enters DONE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = RUN;
      RUN:  if (!(issue_cnt < CLUSTERS) && credit_empty) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      issue_cnt         <= '0;
      wb_cnt            <= '0;
      error             <= 1'b0;
      mem_write_enable  <= 1'b0;
      mem_write_address <= '0;
      mem_write_data    <= '0;
    end else begin
      mem_write_enable <= res_accept;
      if (res_accept) begin
        mem_write_address <= wb_cnt;
        mem_write_data    <= dp_res_data;
        wb_cnt            <= wb_cnt + 1'b1;
      end
      if (start_accept) begin
        issue_cnt <= '0;
        wb_cnt    <= '0;
      end else if (issue) begin
        issue_cnt <= issue_cnt + 1'b1;
      end
      if (dp_res_valid && !res_accept) error <= 1'b1;
      else if (start_accept)           error <= 1'b0;
    end
  end

endmodule

// File: tb/tb_p_update_sequencer.sv
// Bench for p_update_sequencer: three instances (4 clusters/4 credits,
// 4 clusters/2 credits, 1 cluster/1 credit) driven by a datapath and memory model.
module tb_p_update_sequencer;
  import p_update_sequencer_pkg::*;

  localparam int W  = P_WORD_WIDTH;
  localparam int AW = SOLVER_ADDRESS_WIDTH;

  logic    clk = 1'b0;
  logic    rst;
  logic    start_s [3];
  logic    ready_s [3];
  logic    res_v_s [3];
  logic    busy_s  [3];
  logic    done_s  [3];
  logic    err_s   [3];
  logic    opv_s   [3];
  logic    mwe_s   [3];
  p_word_t rdata_s [3];
  p_word_t opd_s   [3];
  p_word_t resd_s  [3];
  p_word_t wdata_s [3];
  logic [AW-1:0] raddr_s [3];
  logic [AW-1:0] waddr_s [3];
  p_word_t pmem [3][4];

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned NC = (g == 2) ? 1 : 4;
    localparam int unsigned MO = (g == 0) ? 4 : ((g == 1) ? 2 : 1);
    p_update_sequencer #(
      .number_of_clusters             (NC),
      .number_of_equations_per_cluster(9),
      .element_width                  (32),
      .address_width                  (AW),
      .max_outstanding                (MO)
    ) dut (
      .clk              (clk),
      .rst              (rst),
      .start            (start_s[g]),
      .busy             (busy_s[g]),
      .done             (done_s[g]),
      .error            (err_s[g]),
      .mem_read_address (raddr_s[g]),
      .mem_read_data    (rdata_s[g]),
      .dp_op_valid      (opv_s[g]),
      .dp_op_data       (opd_s[g]),
      .dp_op_ready      (ready_s[g]),
      .dp_res_valid     (res_v_s[g]),
      .dp_res_data      (resd_s[g]),
      .mem_write_enable (mwe_s[g]),
      .mem_write_address(waddr_s[g]),
      .mem_write_data   (wdata_s[g])
    );
    assign rdata_s[g] = (raddr_s[g] < AW'(NC)) ? pmem[g][raddr_s[g][1:0]] : '0;
  end

  function automatic int nc_of(input int k);
    return (k == 2) ? 1 : 4;
  endfunction

  function automatic int mo_of(input int k);
    return (k == 0) ? 4 : ((k == 1) ? 2 : 1);
  endfunction

  function automatic p_word_t rand_word();
    p_word_t w;
    for (int i = 0; i < W / 32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  function automatic void check(input string name, input p_word_t act, input p_word_t exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endfunction

  // One full pass on instance k. lat = 0 picks a random per-op latency;
  // rnd randomizes ready and injects stray start pulses.
  task automatic run_pass(input int k, input int lat, input logic [3:0] pat, input bit rnd,
                          input int exp_done, input logic [31:0] exp_mask);
    int n = nc_of(k);
    int mo = mo_of(k);
    int issued = 0, returned = 0, wrote = 0, last_wr = -1, last_due = 0, due, l;
    int due_q[$];
    p_word_t dat_q[$];
    p_word_t key, init[4];
    logic [31:0] mask = '0;
    bit exp_valid, finished = 1'b0;
    key = rand_word();
    for (int a = 0; a < n; a++) begin
      init[a] = rand_word();
      pmem[k][a] = init[a];
    end
    @(negedge clk);
    start_s[k] = 1'b1;
    #1 check("busy_before_start", p_word_t'(busy_s[k]), '0);
    for (int cyc = 1; cyc <= 200 && !finished; cyc++) begin
      @(negedge clk);
      start_s[k] = rnd ? ($urandom % 4 == 0) : 1'b0;
      ready_s[k] = rnd ? ($urandom % 3 != 0) : pat[(cyc - 1) % 4];
      exp_valid = (issued < n) && (issued - returned < mo);
      if (due_q.size() > 0 && due_q[0] == cyc) begin
        res_v_s[k] = 1'b1;
        resd_s[k]  = dat_q[0];
        void'(due_q.pop_front());
        void'(dat_q.pop_front());
        returned++;
      end else begin
        res_v_s[k] = 1'b0;
        resd_s[k]  = rand_word();
      end
      #1;
      check("op_valid", p_word_t'(opv_s[k]), p_word_t'(exp_valid));
      check("read_address", p_word_t'(raddr_s[k]), p_word_t'(issued));
      check("busy_in_pass", p_word_t'(busy_s[k]), p_word_t'(1));
      check("error_in_pass", p_word_t'(err_s[k]), '0);
      if (mwe_s[k]) begin
        check("write_address", p_word_t'(waddr_s[k]), p_word_t'(wrote));
        if (wrote < n) check("write_data", wdata_s[k], init[wrote] ^ key);
        else check("extra_write", p_word_t'(wrote), p_word_t'(n - 1));
        pmem[k][waddr_s[k][1:0]] = wdata_s[k];
        wrote++;
        last_wr = cyc;
      end
      if (opv_s[k] && ready_s[k]) begin
        if (issued < n) check("op_data", opd_s[k], init[issued]);
        l = (lat > 0) ? lat : $urandom_range(1, 6);
        due = (cyc + l > last_due + 1) ? cyc + l : last_due + 1;
        last_due = due;
        due_q.push_back(due);
        dat_q.push_back(opd_s[k] ^ key);
        issued++;
        if (cyc < 32) mask[cyc] = 1'b1;
      end
      if (done_s[k]) begin
        finished = 1'b1;
        check("done_after_last_write", p_word_t'(cyc), p_word_t'(last_wr + 1));
        check("write_count", p_word_t'(wrote), p_word_t'(n));
        if (exp_done > 0) check("done_cycle", p_word_t'(cyc), p_word_t'(exp_done));
        if (exp_mask != '0) check("issue_cycles", p_word_t'(mask), p_word_t'(exp_mask));
      end
    end
    start_s[k] = 1'b0;
    ready_s[k] = 1'b0;
    res_v_s[k] = 1'b0;
    if (!finished) begin
      total++;
      $display("FAIL pass_timeout: no done on instance %0d within 200 cycles", k);
    end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      #1;
      check("idle_after_done", p_word_t'({busy_s[k], done_s[k], mwe_s[k]}), '0);
    end
    for (int a = 0; a < n; a++) check("final_memory", pmem[k][a], init[a] ^ key);
  endtask

  typedef struct {
    int          inst;
    int          lat;
    logic [3:0]  pat;
    int          exp_done;
    logic [31:0] exp_mask;
  } vec_t;

  initial begin
    vec_t vecs[6];
    int wr;
    vecs[0] = '{inst: 0, lat: 2, pat: 4'b1111, exp_done: 8,  exp_mask: 32'h1E};
    vecs[1] = '{inst: 1, lat: 5, pat: 4'b1111, exp_done: 15, exp_mask: 32'h186};
    vecs[2] = '{inst: 0, lat: 2, pat: 4'b1001, exp_done: 12, exp_mask: 32'h132};
    vecs[3] = '{inst: 0, lat: 1, pat: 4'b1111, exp_done: 7,  exp_mask: 32'h1E};
    vecs[4] = '{inst: 1, lat: 2, pat: 4'b1111, exp_done: 9,  exp_mask: 32'h36};
    vecs[5] = '{inst: 2, lat: 2, pat: 4'b1111, exp_done: 5,  exp_mask: 32'h2};

    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      start_s[k] = 1'b0;
      ready_s[k] = 1'b0;
      res_v_s[k] = 1'b0;
      resd_s[k]  = '0;
      for (int a = 0; a < 4; a++) pmem[k][a] = '0;
    end
    repeat (2) @(negedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      check("reset_flags", p_word_t'({busy_s[k], done_s[k], err_s[k], opv_s[k], mwe_s[k]}), '0);
      check("reset_addresses", p_word_t'({raddr_s[k], waddr_s[k]}), '0);
      check("reset_write_data", wdata_s[k], '0);
    end
    rst = 1'b0;

    for (int i = 0; i < 6; i++)
      run_pass(vecs[i].inst, vecs[i].lat, vecs[i].pat, 1'b0, vecs[i].exp_done, vecs[i].exp_mask);

    // Reset after two of four writes, then a clean restart from address 0.
    for (int a = 0; a < 4; a++) pmem[0][a] = rand_word();
    wr = 0;
    @(negedge clk);
    start_s[0] = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      start_s[0] = 1'b0;
      ready_s[0] = 1'b1;
      res_v_s[0] = (c >= 3);
      resd_s[0]  = rand_word();
      #1;
      if (mwe_s[0]) wr++;
    end
    check("writes_before_reset", p_word_t'(wr), p_word_t'(2));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ready_s[0] = 1'b0;
    res_v_s[0] = 1'b0;
    #1;
    check("after_reset_flags", p_word_t'({busy_s[0], done_s[0], err_s[0], opv_s[0], mwe_s[0]}), '0);
    check("after_reset_read_address", p_word_t'(raddr_s[0]), '0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1 check("no_write_after_reset", p_word_t'({mwe_s[0], busy_s[0]}), '0);
    end
    run_pass(0, 2, 4'b1111, 1'b0, 8, 32'h1E);

    // Stray result while idle sets a sticky error; the next start clears it.
    @(negedge clk);
    res_v_s[2] = 1'b1;
    resd_s[2]  = rand_word();
    @(negedge clk);
    res_v_s[2] = 1'b0;
    #1;
    check("idle_result_error", p_word_t'(err_s[2]), p_word_t'(1));
    check("idle_result_no_write", p_word_t'(mwe_s[2]), '0);
    @(negedge clk);
    #1 check("error_sticky", p_word_t'(err_s[2]), p_word_t'(1));
    run_pass(2, 2, 4'b1111, 1'b0, 5, 32'h2);

    for (int i = 0; i < 10; i++) run_pass($urandom % 3, 0, 4'b1111, 1'b1, 0, '0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/p_update_sequencer.md
# p_update_sequencer

Controller that runs one full update pass over the P vector memory in the iterative solver. It walks every cluster address, reads each P word and hands it to the external P-update datapath over a valid/ready handshake. It takes the in-order results back and writes them into the same address, with several operations in flight at once. It owns both ports of the P memory for the whole pass and signals completion with a single-cycle `done`.

## Interface
- `number_of_clusters`, 1: words in P memory; the pass covers addresses 0 .. number_of_clusters-1.
- `number_of_equations_per_cluster`, 9: elements per word.
- `element_width`, 32: bits per element.
- `address_width`, 20: memory address width.
- `max_outstanding`, 4: maximum number of ops issued but not yet returned (≥1).

Ports, one per line (W = number_of_equations_per_cluster*element_width):
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a pass; sampled only in IDLE.
- `busy`  out  1  high from the cycle after accepted start until `done`, inclusive.
- `done`  out  1  one-cycle pulse; the pass is complete and all writes are committed.
- `error`  out  1  sticky; set when a result arrives with nothing outstanding; cleared by `rst` or accepted `start`.
- `mem_read_address`  out  address_width  to the P memory read port, which reads combinationally.
- `mem_read_data`  in  W  P memory read output.
- `dp_op_valid`  out  1  op offered to the datapath.
- `dp_op_data`  out  W  equals `mem_read_data`, combinational pass-through.
- `dp_op_ready`  in  1  datapath accepts the op.
- `dp_res_valid`  in  1  result returned; results come back in issue order; no backpressure.
- `dp_res_data`  in  W  updated P word.
- `mem_write_enable`  out  1  registered write strobe.
- `mem_write_address`  out  address_width  registered.
- `mem_write_data`  out  W  registered.

## Operation
- States:
  - IDLE: accepted `start` → RUN.
  - RUN: when all ops are issued, outstanding is 0 and no write is pending → DONE.
  - DONE: lasts one cycle, `done`=1 → IDLE.
- `issue_cnt` holds the next read address. It resets to 0 on an accepted start and increments on each transfer (`dp_op_valid & dp_op_ready`).
- `dp_op_valid` = RUN & issue_cnt < number_of_clusters & outstanding < max_outstanding.
- `mem_read_address` = issue_cnt (zero-extended) at all times.
- `wb_cnt` holds the next write address. It resets to 0 on start and increments on each accepted result.
- On `dp_res_valid` with outstanding > 0, the next edge sets:
  - `mem_write_enable`=1
  - `mem_write_address`=wb_cnt
  - `mem_write_data`=dp_res_data
- Otherwise `mem_write_enable`=0.
- Outstanding counter behaviour:
  - issue only: +1.
  - result only: −1.
  - issue and result in the same cycle: unchanged.
- Reads always lead writes, so no read-after-write hazard exists within a pass.
- Unexpected result (outstanding = 0, or not in RUN): ignored, no write, `error` set.
- `start` while not IDLE: ignored.
- `dp_res_valid` is honoured in RUN even when `dp_op_valid` is low (drain phase).

## Timing
- Reset values: state IDLE; `busy`, `done`, `error`, `dp_op_valid`, `mem_write_enable` = 0; counters, `mem_write_address` and `mem_write_data` = 0.
- Start accepted at edge 0 → RUN in cycle 1; first `dp_op_valid` in cycle 1 with address 0.
- Result in cycle t → `mem_write_enable` in cycle t+1; the write lands at edge t+1.
- `done` is high in the cycle after the last `mem_write_enable` cycle.
- Peak throughput is one op per cycle while outstanding < max_outstanding.
- `rst` mid-pass: the next cycle is IDLE with all outputs at reset values; no further writes. Results still in flight afterwards are flagged as `error` only if they arrive in RUN of a new pass with outstanding = 0.
- number_of_clusters = 1: a single issue and a single write, then `done`.

## Structure
- Shared solver package holds:
  - the state enum (IDLE/RUN/DONE);
  - the W-width word type;
  - the address width constant shared with the P, R and X memories.
- One natural sub-module: `credit_counter`, an up/down outstanding counter with a limit-reached flag, reusable by the R/X sequencers.
- Everything else is flat.

## Test plan
- number_of_clusters=4, ready always 1, fixed 2-cycle datapath latency → ops in cycles 1–4 at addresses 0–3; writes to addresses 0–3 with the matching data; `done` one cycle after the last write; `error`=0.
- max_outstanding=2, datapath latency 5 → `dp_op_valid` drops after 2 issues; outstanding never exceeds 2; all 4 writes land in order.
- `dp_op_ready` toggling 1,0,0,1 → `mem_read_address` holds while stalled; each address is issued exactly once.
- Result arriving in the same cycle as an issue at outstanding=1 → outstanding stays 1; no lost or duplicate write.
- `rst` asserted after 2 of 4 writes → IDLE the next cycle; `mem_write_enable` stays 0; a new `start` restarts at address 0.
- `dp_res_valid` pulsed while IDLE → no write, `error`=1; `error` cleared by the next accepted `start`.
